// File: rtl/field_mul_arbiter.sv
// rtl/field_mul_arbiter.sv - round-robin sharing of one field multiplier
//
// Purpose: lets N_REQ requesters share a single field_multiplier while each one
// keeps its private field-unit handshake (en edge in; ready/ready_pulse/c out).
// Arbitration is work-conserving round-robin. Each requester has its own result
// register. Field is GF(q) with q = 2^61-1, so F_NBITS = 61.
//
// Ports (field_mul_arbiter):
//   clk, rstb         clock, async active-low reset
//   en[N_REQ]         per-requester start; a rising edge starts an op
//   a, b              N_REQ x F_NBITS operands, sampled on the start cycle
//   c                 N_REQ x F_NBITS products, held until the next own completion
//   ready[N_REQ]      requester idle: nothing pending or in flight
//   ready_pulse       one-cycle rising edge of ready
//   busy              shared multiplier owned by this block (ST_WAIT)
//
// Ports (field_multiplier):
//   clk, rstb, en, a, b in; ready, out out. Accepts en while ready; ready
//   drops the next cycle and returns L_MUL cycles after en with out valid.

module field_multiplier #(
  parameter int L_MUL = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        en,
  input  logic [60:0] a,
  input  logic [60:0] b,
  output logic        ready,
  output logic [60:0] out
);
  localparam int CNT_W = $clog2(L_MUL);
  localparam logic [60:0] Q = 61'h1FFF_FFFF_FFFF_FFFF;

  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [60:0]      opa_q, opa_d, opb_q, opb_d, out_q, out_d;
  logic [121:0]     prod;
  logic [61:0]      fold, fold2;
  logic [60:0]      sub, red;

  // Mersenne reduction: 2^61 == 1, so fold the high half onto the low half
  // twice, then one conditional subtract. fold2 is at most 2^61, and
  // 2^61 - q wraps to 1 in 61 bits, which is the right answer.
  always_comb begin
    prod  = 122'(opa_q) * 122'(opb_q);
    fold  = {1'b0, prod[60:0]} + {1'b0, prod[121:61]};
    fold2 = {1'b0, fold[60:0]} + {61'd0, fold[61]};
    sub   = fold2[60:0] - Q;
    red   = (fold2 >= {1'b0, Q}) ? sub : fold2[60:0];
  end

  always_comb begin
    ready_d = ready_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    out_d   = out_q;
    if (ready_q) begin
      if (en) begin
        ready_d = 1'b0;
        cnt_d   = CNT_W'(L_MUL - 2);
        opa_d   = a;
        opb_d   = b;
      end
    end else if (cnt_q == '0) begin
      ready_d = 1'b1;
      out_d   = red;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_q <= 1'b1;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      out_q   <= '0;
    end else begin
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      out_q   <= out_d;
    end
  end

  assign ready = ready_q;
  assign out   = out_q;
endmodule

module field_mul_arbiter #(
  parameter  int N_REQ   = 4,
  localparam int IDX_W   = $clog2(N_REQ),
  localparam int F_NBITS = 61
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [N_REQ-1:0]           en,
  input  logic [N_REQ*F_NBITS-1:0]   a,
  input  logic [N_REQ*F_NBITS-1:0]   b,
  output logic [N_REQ*F_NBITS-1:0]   c,
  output logic [N_REQ-1:0]           ready,
  output logic [N_REQ-1:0]           ready_pulse,
  output logic                       busy
);
  localparam int L_MUL = 4;

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

  state_t                            state_q, state_d;
  logic [N_REQ-1:0]                  pending_q, pending_d;
  logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                  gnt_q, gnt_d;
  logic [N_REQ-1:0]                  en_dly_q, en_dly_d;
  logic [N_REQ-1:0]                  ready_dly_q, ready_dly_d;
  logic [N_REQ-1:0][F_NBITS-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [N_REQ-1:0][F_NBITS-1:0]     c_q, c_d;
  logic                              mul_en_q, mul_en_d;
  logic [F_NBITS-1:0]                mul_a_q, mul_a_d, mul_b_q, mul_b_d;

  logic [N_REQ-1:0][F_NBITS-1:0]     a_arr, b_arr;
  logic [N_REQ-1:0]                  start, ready_ns, accept;
  logic [IDX_W-1:0]                  winner;
  logic                              found, do_grant, inflight;
  logic                              mul_ready, mul_ok;
  logic [F_NBITS-1:0]                mul_out;

  assign a_arr = a;
  assign b_arr = b;

  function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] base,
                                               input int unsigned k);
    logic [IDX_W:0] s;
    s = {1'b0, base} + (IDX_W+1)'(k);
    if (s >= (IDX_W+1)'(N_REQ)) s = s - (IDX_W+1)'(N_REQ);
    return s[IDX_W-1:0];
  endfunction

  field_multiplier #(.L_MUL(L_MUL)) iMul (
    .clk   (clk),
    .rstb  (rstb),
    .en    (mul_en_q),
    .a     (mul_a_q),
    .b     (mul_b_q),
    .ready (mul_ready),
    .out   (mul_out)
  );

  // The multiplier's ready only falls the cycle after en, so mask it while
  // our own en pulse is still in the air.
  assign mul_ok   = mul_ready & ~mul_en_q;
  assign inflight = (state_q == ST_WAIT);
  assign busy     = inflight;

  // ready_ns is readiness before this cycle's start term; it decides whether
  // a start is accepted, while the exported ready also drops on the start.
  always_comb begin
    start = en & ~en_dly_q;
    for (int i = 0; i < N_REQ; i++) begin
      ready_ns[i] = ~pending_q[i] & ~(inflight && (gnt_q == IDX_W'(i)));
    end
    accept      = start & ready_ns;
    ready       = ready_ns & ~start;
    ready_pulse = ready & ~ready_dly_q;
  end

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && pending_q[add_mod(rr_ptr_q, k)]) begin
        winner = add_mod(rr_ptr_q, k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    c_d         = c_q;
    mul_en_d    = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    en_dly_d    = en;
    ready_dly_d = ready;
    do_grant    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|pending_q && mul_ok) begin
          do_grant = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mul_ok) begin
          c_d[gnt_q] = mul_out;
          // Back-to-back: the next grant rides the completion cycle.
          if (|pending_q) do_grant = 1'b1;
          else            state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_grant) begin
      gnt_d             = winner;
      rr_ptr_d          = add_mod(winner, 1);
      pending_d[winner] = 1'b0;
      mul_a_d           = op_a_q[winner];
      mul_b_d           = op_b_q[winner];
      mul_en_d          = 1'b1;
    end

    // An accepted requester was not pending, so it can never be the winner
    // cleared above in the same cycle.
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        op_a_d[i]    = a_arr[i];
        op_b_d[i]    = b_arr[i];
        pending_d[i] = 1'b1;
      end
    end
  end

  // en_dly and ready_dly reset high so that en held through reset is not an
  // edge and ready coming out of reset is not a pulse.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      en_dly_q    <= '1;
      ready_dly_q <= '1;
      op_a_q      <= '0;
      op_b_q      <= '0;
      c_q         <= '0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      en_dly_q    <= en_dly_d;
      ready_dly_q <= ready_dly_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      c_q         <= c_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign c = c_q;
endmodule
